// File: rtl/mem_arbiter_if.sv
// Requester ports 0/1 plus the synchronous program-memory port of mem_arbiter.
// master = requesters and memory model side, slave = the arbiter.
interface mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              req0;
    logic [ADDR_W-1:0] addr0;
    logic              gnt0;
    logic [DATA_W-1:0] rdata0;
    logic              valid0;
    logic              req1;
    logic [ADDR_W-1:0] addr1;
    logic              gnt1;
    logic [DATA_W-1:0] rdata1;
    logic              valid1;
    logic [ADDR_W-1:0] memAddr;
    logic              memStrobe;
    logic [DATA_W-1:0] memDataRead;

    modport master (
        output req0, addr0, req1, addr1, memDataRead,
        input  gnt0, rdata0, valid0, gnt1, rdata1, valid1, memAddr, memStrobe
    );

    modport slave (
        input  req0, addr0, req1, addr1, memDataRead,
        output gnt0, rdata0, valid0, gnt1, rdata1, valid1, memAddr, memStrobe
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port read arbiter for a 1-cycle synchronous memory: gnt at t, strobe t+1, valid t+3; requests are level-held until gnt.
// MEM_ARBITER_ROUND_ROBIN_EN selects round-robin on contention; default build gives port 0 fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_port;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic              r_valid0;
    logic              r_valid1;
    logic              w_arb;
    logic              w_win;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic              r_last;
`endif

    // DATA doubles as an arbitration cycle so a pending request overlaps the read return.
    always_comb begin
        w_state_nxt = r_state;
        w_arb       = 1'b0;
        w_win       = 1'b0;
        case (r_state)
            IDLE, DATA: begin
                w_state_nxt = IDLE;
                if (bus.req0 || bus.req1) begin
                    w_arb       = 1'b1;
                    w_state_nxt = ISSUE;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
                    if (bus.req0 && bus.req1)
                        w_win = ~r_last;
                    else
                        w_win = bus.req1;
`else
                    w_win = ~bus.req0;
`endif
                end
            end
            ISSUE:   w_state_nxt = DATA;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_port  <= 1'b0;
            r_addr  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_arb) begin
                r_port <= w_win;
                r_addr <= w_win ? bus.addr1 : bus.addr0;
            end
        end
    end

`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_last <= 1'b1;
        else if (w_arb)
            r_last <= w_win;
    end
`endif

    // Capture uses the port latched for the access in flight, not one granted this cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else begin
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
            if (r_state == DATA) begin
                if (r_port) begin
                    r_rdata1 <= bus.memDataRead;
                    r_valid1 <= 1'b1;
                end else begin
                    r_rdata0 <= bus.memDataRead;
                    r_valid0 <= 1'b1;
                end
            end
        end
    end

    assign bus.gnt0      = w_arb & ~w_win & ~reset;
    assign bus.gnt1      = w_arb &  w_win & ~reset;
    assign bus.memStrobe = (r_state == ISSUE);
    assign bus.memAddr   = r_addr;
    assign bus.rdata0    = r_rdata0;
    assign bus.rdata1    = r_rdata1;
    assign bus.valid0    = r_valid0;
    assign bus.valid1    = r_valid1;
endmodule
